fetch_decode_unit: RTL and testbench
====================================

Name: fetch_decode_unit

Overview:
- Upstream stage of the 8-bit single-cycle datapath.
- Holds the program counter and fetches 8-bit instructions over a request/valid handshake to instruction memory.
- Decodes each instruction into the register-number, raw-immediate, ImmSel and RegWrite controls that drive the register file.
- Resolves relative branches internally and stops on a HALT encoding.

Parameters:
- PC_WIDTH, 8: width of the program counter and of Imem_Addr.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- Clk  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-low reset
- Imem_Req  output  1  fetch request, high only in FETCH
- Imem_Addr  output  PC_WIDTH  fetch address, equals PC
- Imem_Rdata  input  8  instruction returned by memory
- Imem_Valid  input  1  Imem_Rdata valid; sampled only in FETCH
- Stall  input  1  downstream hold; freezes issue
- Instr_Valid  output  1  decoded instruction present (ISSUE state)
- Instr  output  8  captured instruction
- Read_Write_Reg_Num  output  3  Instr[5:3]
- Immediate_Raw  output  6  Instr[5:0]
- ImmSel  output  1  1 = 6-bit immediate class
- RegWrite  output  1  register-file write strobe, one cycle per instruction
- Halted  output  1  HALT reached
- PC  output  PC_WIDTH  current program counter

Behaviour:
- Reset (Reset=0, asynchronous) forces the following, regardless of state, including mid-fetch or mid-issue:
  - state=FETCH, PC=RESET_PC
  - Instr=8'h00, Instr_Valid=0, RegWrite=0, Halted=0
  - Imem_Req is 1 after reset release, because the state is FETCH.
- Instruction decode (Instr[7:6]):
  - 00 = ALU/read: ImmSel=0, no write.
  - 01 = load-imm3: ImmSel=0, write.
  - 10 = load-imm6: ImmSel=1, write.
  - 11 = branch: ImmSel=1, no write.
  - 8'hC0 (branch, offset 0) = HALT.
- States:
  - FETCH: Imem_Req=1, Imem_Addr=PC.
    - Imem_Valid=1 at a rising edge: Instr<=Imem_Rdata, go to ISSUE.
    - Otherwise stay in FETCH; wait indefinitely.
  - ISSUE: Instr_Valid=1, decoded outputs driven from Instr.
    - Stall=1: hold all outputs, PC unchanged.
    - Stall=0 and Instr=8'hC0: go to HALT; PC unchanged.
    - Stall=0, branch: PC <= PC + 1 + sign-extend(Instr[5:0]); go to FETCH.
    - Stall=0, otherwise: PC <= PC + 1; go to FETCH.
  - HALT: Halted=1, Imem_Req=0, Instr_Valid=0. Left only by reset.
- RegWrite = Instr_Valid & ~Stall & (Instr[7:6]==01 or 10). Asserted for exactly one cycle per retired write instruction; never while stalled.
- PC arithmetic is modulo 2^PC_WIDTH; wraps silently in both directions (FF+1 -> 00, 00-2 -> FE).
- Imem_Valid outside FETCH is ignored. Stall outside ISSUE is ignored.
- Throughput: at most one instruction per 2 cycles with zero-wait memory. Latency from Imem_Valid edge to Instr_Valid is 1 cycle.
- Decoded outputs outside ISSUE reflect the last captured Instr; consumers qualify them with Instr_Valid.

Optional Feature:
- Macro: RETIRE_COUNTER_EN.
- Defined:
  - Adds output Retire_Count, 16 bits, reset to 0.
  - Increments on every ISSUE cycle with Stall=0, including HALT retirement.
  - Saturates at 16'hFFFF.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset release, memory returns 8'h4B (load-imm3, reg 1) with Imem_Valid on first FETCH cycle -> Instr_Valid next cycle; Read_Write_Reg_Num=1, Immediate_Raw=6'h0B, ImmSel=0, RegWrite=1 for exactly 1 cycle; PC 00->01.
- ISSUE of 8'h9F with Stall high 3 cycles -> outputs frozen; RegWrite=0 during stall; RegWrite=1 on the cycle Stall drops; PC advances once.
- Branch 8'hFE at PC=05 (offset -2) -> next Imem_Addr=04. Branch 8'h82? no: branch 8'hC1 at PC=FF -> Imem_Addr=01 (wrap).
- Fetch 8'hC0 at PC=10 -> Halted=1, Imem_Req=0, PC stays 10; later Imem_Valid pulses cause no change.
- Imem_Valid withheld 5 cycles -> Imem_Req held, Imem_Addr stable, Instr_Valid=0; Reset low mid-ISSUE -> all outputs return to reset values immediately, without waiting for a clock edge.
- With RETIRE_COUNTER_EN: 4 instructions plus HALT, including one stalled issue -> Retire_Count=5.

Source files
------------

// File: rtl/fetch_decode_unit.sv
// Fetch/decode front end: PC, imem request/valid handshake, instruction decode, branch resolve, HALT.
// Optional RETIRE_COUNTER_EN adds a saturating 16-bit Retire_Count output.
module fetch_decode_unit #(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                Clk,
  input  logic                Reset,
  output logic                Imem_Req,
  output logic [PC_WIDTH-1:0] Imem_Addr,
  input  logic [7:0]          Imem_Rdata,
  input  logic                Imem_Valid,
  input  logic                Stall,
  output logic                Instr_Valid,
  output logic [7:0]          Instr,
  output logic [2:0]          Read_Write_Reg_Num,
  output logic [5:0]          Immediate_Raw,
  output logic                ImmSel,
  output logic                RegWrite,
  output logic                Halted,
`ifdef RETIRE_COUNTER_EN
  output logic [15:0]         Retire_Count,
`endif
  output logic [PC_WIDTH-1:0] PC
);

  typedef enum logic [1:0] {FETCH, ISSUE, HALT} state_t;

  state_t              state;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] offset;
  logic [PC_WIDTH-1:0] pc_next;
  logic                is_branch;
  logic                is_halt;
  logic                is_write;
  logic                retire;

  always_comb begin
    is_branch = (Instr[7:6] == 2'b11);
    is_halt   = (Instr == 8'hC0);
    is_write  = (Instr[7:6] == 2'b01) || (Instr[7:6] == 2'b10);
    // Sign-extend the 6-bit branch offset to PC width; arithmetic wraps modulo 2^PC_WIDTH.
    offset    = PC_WIDTH'($signed(Instr[5:0]));
    pc_next   = pc_q + PC_WIDTH'(1) + (is_branch ? offset : '0);
    retire    = (state == ISSUE) && !Stall;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= FETCH;
      pc_q  <= RESET_PC;
      Instr <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (Imem_Valid) begin
            Instr <= Imem_Rdata;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (!Stall) begin
            if (is_halt) begin
              state <= HALT;
            end else begin
              pc_q  <= pc_next;
              state <= FETCH;
            end
          end
        end
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

  assign Imem_Req           = (state == FETCH);
  assign Imem_Addr          = pc_q;
  assign PC                 = pc_q;
  assign Instr_Valid        = (state == ISSUE);
  assign Halted             = (state == HALT);
  assign Read_Write_Reg_Num = Instr[5:3];
  assign Immediate_Raw      = Instr[5:0];
  assign ImmSel             = Instr[7];
  assign RegWrite           = Instr_Valid && !Stall && is_write;

`ifdef RETIRE_COUNTER_EN
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Retire_Count <= '0;
    end else if (retire && (Retire_Count != '1)) begin
      Retire_Count <= Retire_Count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Scoreboard bench for fetch_decode_unit: directed program with hand-computed decode/PC values.
module tb_fetch_decode_unit;

  typedef struct {
    logic [7:0] instr;
    logic [7:0] addr;
    logic [2:0] rn;
    logic [5:0] imm;
    logic       sel;
    logic       wr;
    int         stall;
    int         wait_n;
  } vec_t;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Imem_Req;
  logic [7:0] Imem_Addr;
  logic [7:0] Imem_Rdata;
  logic       Imem_Valid;
  logic       Stall;
  logic       Instr_Valid;
  logic [7:0] Instr;
  logic [2:0] Read_Write_Reg_Num;
  logic [5:0] Immediate_Raw;
  logic       ImmSel;
  logic       RegWrite;
  logic       Halted;
  logic [7:0] PC;
`ifdef RETIRE_COUNTER_EN
  logic [15:0] Retire_Count;
`endif

  int   checks = 0;
  int   fails  = 0;
  vec_t exp_q[$];
  vec_t prog[9];

  fetch_decode_unit #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
    .Clk(Clk), .Reset(Reset), .Imem_Req(Imem_Req), .Imem_Addr(Imem_Addr),
    .Imem_Rdata(Imem_Rdata), .Imem_Valid(Imem_Valid), .Stall(Stall),
    .Instr_Valid(Instr_Valid), .Instr(Instr), .Read_Write_Reg_Num(Read_Write_Reg_Num),
    .Immediate_Raw(Immediate_Raw), .ImmSel(ImmSel), .RegWrite(RegWrite), .Halted(Halted),
`ifdef RETIRE_COUNTER_EN
    .Retire_Count(Retire_Count),
`endif
    .PC(PC)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ISSUE cycle is compared against the head of the expected queue.
  always @(negedge Clk) begin
    if (Reset) begin
      if (Instr_Valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL issue_unexpected: got instr %h expected none", Instr);
        end else begin
          checks++;
          if ({Instr, PC, Read_Write_Reg_Num, Immediate_Raw, ImmSel} !==
              {exp_q[0].instr, exp_q[0].addr, exp_q[0].rn, exp_q[0].imm, exp_q[0].sel}) begin
            fails++;
            $display("FAIL issue_decode: got instr=%h pc=%h rn=%0d imm=%h sel=%b expected instr=%h pc=%h rn=%0d imm=%h sel=%b",
                     Instr, PC, Read_Write_Reg_Num, Immediate_Raw, ImmSel,
                     exp_q[0].instr, exp_q[0].addr, exp_q[0].rn, exp_q[0].imm, exp_q[0].sel);
          end
          checks++;
          if (RegWrite !== (Stall ? 1'b0 : exp_q[0].wr)) begin
            fails++;
            $display("FAIL issue_regwrite: got %b expected %b (stall=%b instr=%h)",
                     RegWrite, (Stall ? 1'b0 : exp_q[0].wr), Stall, exp_q[0].instr);
          end
          if (!Stall) void'(exp_q.pop_front());
        end
      end else begin
        checks++;
        if (RegWrite !== 1'b0) begin
          fails++;
          $display("FAIL idle_regwrite: got %b expected 0", RegWrite);
        end
      end
    end
  end

  task automatic fetch(input vec_t v);
    int n = 0;
    while (!Imem_Req && n < 10) begin
      @(posedge Clk); #1;
      n++;
    end
    if (!Imem_Req) begin
      chk("fetch_req_timeout", Imem_Req, 1);
      return;
    end
    for (int i = 0; i < v.wait_n; i++) begin
      chk("wait_req", Imem_Req, 1);
      chk("wait_addr", Imem_Addr, v.addr);
      chk("wait_ivalid", Instr_Valid, 0);
      @(posedge Clk); #1;
    end
    chk("fetch_addr", Imem_Addr, v.addr);
    exp_q.push_back(v);
    Imem_Rdata = v.instr;
    Imem_Valid = 1'b1;
    @(posedge Clk); #1;
    Imem_Valid = 1'b0;
    Imem_Rdata = '0;
    if (v.stall > 0) begin
      Stall = 1'b1;
      repeat (v.stall) begin
        @(posedge Clk); #1;
      end
      Stall = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t r;
    //           instr  addr   rn    imm    sel   wr  stall wait
    prog[0] = '{8'h4B, 8'h00, 3'd1, 6'h0B, 1'b0, 1'b1, 0, 0};
    prog[1] = '{8'h9F, 8'h01, 3'd3, 6'h1F, 1'b1, 1'b1, 3, 0};
    prog[2] = '{8'h03, 8'h02, 3'd0, 6'h03, 1'b0, 1'b0, 0, 0};
    prog[3] = '{8'hC1, 8'h03, 3'd0, 6'h01, 1'b1, 1'b0, 0, 0};
    prog[4] = '{8'hFE, 8'h05, 3'd7, 6'h3E, 1'b1, 1'b0, 0, 0};
    prog[5] = '{8'hFA, 8'h04, 3'd7, 6'h3A, 1'b1, 1'b0, 0, 5};
    prog[6] = '{8'hC1, 8'hFF, 3'd0, 6'h01, 1'b1, 1'b0, 0, 0};
    prog[7] = '{8'hCE, 8'h01, 3'd1, 6'h0E, 1'b1, 1'b0, 0, 0};
    prog[8] = '{8'hC0, 8'h10, 3'd0, 6'h00, 1'b1, 1'b0, 0, 0};

    Reset = 1'b0; Imem_Valid = 1'b0; Imem_Rdata = '0; Stall = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_pc", PC, 8'h00);
    chk("rst_instr", Instr, 8'h00);
    chk("rst_ivalid", Instr_Valid, 0);
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_halted", Halted, 0);
    Reset = 1'b1;
    #1;
    chk("req_after_rst", Imem_Req, 1);

    for (int i = 0; i < 9; i++) fetch(prog[i]);

    @(posedge Clk); #1;
    chk("halt_halted", Halted, 1);
    chk("halt_req", Imem_Req, 0);
    chk("halt_ivalid", Instr_Valid, 0);
    chk("halt_pc", PC, 8'h10);
    chk("queue_drained", exp_q.size(), 0);
`ifdef RETIRE_COUNTER_EN
    chk("retire_count", Retire_Count, 16'd9);
`endif
    for (int i = 0; i < 3; i++) begin
      Imem_Rdata = 8'h4B;
      Imem_Valid = 1'b1;
      @(posedge Clk); #1;
      Imem_Valid = 1'b0;
      @(posedge Clk); #1;
    end
    chk("halt_hold_pc", PC, 8'h10);
    chk("halt_hold_halted", Halted, 1);
    chk("halt_hold_instr", Instr, 8'hC0);
    chk("halt_hold_ivalid", Instr_Valid, 0);

    Reset = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b1;
    #1;
    chk("rerst_addr", Imem_Addr, 8'h00);
    r = '{8'h4B, 8'h00, 3'd1, 6'h0B, 1'b0, 1'b1, 0, 0};
    exp_q.push_back(r);
    Imem_Rdata = 8'h4B;
    Imem_Valid = 1'b1;
    @(posedge Clk); #1;
    Imem_Valid = 1'b0;
    Stall = 1'b1;
    @(posedge Clk); #1;
    chk("pre_async_ivalid", Instr_Valid, 1);
    #2 Reset = 1'b0;
    #1;
    chk("async_ivalid", Instr_Valid, 0);
    chk("async_instr", Instr, 8'h00);
    chk("async_regwrite", RegWrite, 0);
    chk("async_pc", PC, 8'h00);
    chk("async_halted", Halted, 0);
`ifdef RETIRE_COUNTER_EN
    chk("async_retire_count", Retire_Count, 16'd0);
`endif
    Stall = 1'b0;
    exp_q.delete();
    @(posedge Clk); #1;
    Reset = 1'b1;
    repeat (2) @(posedge Clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
